sync_long_frame_ctrl: RTL

// Next-generation long-preamble synchronisation controller. Sits between sync short and the FFT front end.

---
 rtl/sync_long_frame_ctrl_if.sv | 40 ++++
 rtl/sync_long_frame_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_long_frame_ctrl_if.sv
// Bus bundle for sync_long_frame_ctrl.
// master: upstream side (drives strobes, peak data, controls; observes gating outputs).
// slave : the controller itself.
interface sync_long_frame_ctrl_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SYM_W = 8
);
  logic             short_found;
  logic             in_strobe;
  logic             in_phase_strobe;
  logic             in_corr_strobe;
  logic [CNT_W-1:0] peak_idx;
  logic [CNT_W-1:0] peak_metric;
  logic [SYM_W-1:0] num_sym;
  logic             abort;
  logic             phase_sample;
  logic             corr_en;
  logic             phase_calc_en;
  logic             out_strobe;
  logic             providing_long;
  logic             providing_stream;
  logic             sym_start;
  logic [SYM_W-1:0] sym_idx;
  logic             frame_done;
  logic             sync_fail;

  modport master (
    output short_found, in_strobe, in_phase_strobe, in_corr_strobe,
           peak_idx, peak_metric, num_sym, abort,
    input  phase_sample, corr_en, phase_calc_en, out_strobe, providing_long,
           providing_stream, sym_start, sym_idx, frame_done, sync_fail
  );

  modport slave (
    input  short_found, in_strobe, in_phase_strobe, in_corr_strobe,
           peak_idx, peak_metric, num_sym, abort,
    output phase_sample, corr_en, phase_calc_en, out_strobe, providing_long,
           providing_stream, sym_start, sym_idx, frame_done, sync_fail
  );
endinterface

// File: rtl/sync_long_frame_ctrl.sv
// Long-preamble sync controller: aligns to the LTS from the correlator peak,
// then gates out the LTS and num_sym data symbols, skipping each CP.
// Ports: CLK, s_RST (sync, active-low), bus (slave modport: strobes, peak,
// num_sym, abort in; enables, gated strobe, symbol markers, done/fail out).
// Optional: define PEAK_THRESH_EN to reject peaks with peak_metric < PEAK_MIN.
module sync_long_frame_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned N_FFT      = 64,
  parameter int unsigned CP_LEN     = 16,
  parameter int unsigned SETTLE     = 12,
  parameter int unsigned REST_CNT   = 122,
  parameter int unsigned CORR_WIN   = 68,
  parameter int unsigned LONG2_BASE = 25,
  parameter int unsigned SYM_W      = 8,
  parameter int unsigned PEAK_MIN   = 16
) (
  input logic                   CLK,
  input logic                   s_RST,
  sync_long_frame_ctrl_if.slave bus
);

  localparam int unsigned WW = CNT_W + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_REST   = 3'd2;
  localparam logic [2:0] S_CORR   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_LONG   = 3'd5;
  localparam logic [2:0] S_CP     = 3'd6;
  localparam logic [2:0] S_DATA   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [SYM_W-1:0] num_sym_q, num_sym_d;
  logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
  logic             fd_pend_q, fd_pend_d;
  logic             phase_sample_q, phase_sample_d;
  logic             corr_en_q, corr_en_d;
  logic             phase_calc_en_q, phase_calc_en_d;
  logic             out_strobe_q, out_strobe_d;
  logic             providing_long_q, providing_long_d;
  logic             providing_stream_q, providing_stream_d;
  logic             sym_start_q, sym_start_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_fail_q, sync_fail_d;

  logic [WW-1:0]    wait_c;
  logic             peak_bad_c;
  logic             kill_c;
  logic             gate_c;

`ifdef PEAK_THRESH_EN
  assign peak_bad_c = bus.peak_metric < CNT_W'(PEAK_MIN);
`else
  logic unused_peak;
  assign peak_bad_c  = 1'b0;
  assign unused_peak = ^{bus.peak_metric, CNT_W'(PEAK_MIN)};
`endif

  // Two's-complement wait; either top bit set means <0 or >=2^CNT_W.
  assign wait_c = WW'(LONG2_BASE) + WW'(bus.peak_idx) + WW'(67) - WW'(CORR_WIN);
  assign kill_c = bus.abort || bus.short_found;
  assign gate_c = ((state_q == S_LONG) || (state_q == S_DATA)) && bus.in_corr_strobe;

  // Next-state and registered-output logic.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    wait_d             = wait_q;
    num_sym_d          = num_sym_q;
    sym_idx_d          = sym_idx_q;
    fd_pend_d          = 1'b0;
    phase_sample_d     = 1'b0;
    frame_done_d       = 1'b0;
    sync_fail_d        = 1'b0;

    if (state_q == S_IDLE) begin
      // frame_done lands one cycle after the final gated sample
      frame_done_d = fd_pend_q && !bus.abort;
      sym_idx_d    = '0;
      if (bus.short_found) begin
        state_d   = S_SETTLE;
        cnt_d     = '0;
        num_sym_d = bus.num_sym;
      end
    end else if (kill_c) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      sym_idx_d = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (bus.in_phase_strobe && (cnt_q == CNT_W'(SETTLE))) begin
            state_d        = S_REST;
            phase_sample_d = 1'b1;
          end else if (bus.in_strobe && (cnt_q != CNT_W'(SETTLE))) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REST: begin
          if (bus.in_strobe) begin
            if (cnt_q == CNT_W'(REST_CNT - 1)) begin
              state_d = S_CORR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_CORR: begin
          if (bus.in_strobe) begin
            if (cnt_q == CNT_W'(CORR_WIN - 1)) begin
              cnt_d = '0;
              if (peak_bad_c || (|wait_c[WW-1:CNT_W])) begin
                state_d     = S_IDLE;
                sync_fail_d = 1'b1;
              end else begin
                state_d = S_WAIT;
                wait_d  = wait_c[CNT_W-1:0];
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == wait_q) begin
            state_d = S_LONG;
            cnt_d   = '0;
          end else if (bus.in_strobe) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_LONG, S_DATA: begin
          if (bus.in_corr_strobe) begin
            if (cnt_q == CNT_W'(N_FFT - 1)) begin
              cnt_d = '0;
              // LTS is sym_idx 0, so the same test covers both body states
              if (sym_idx_q < num_sym_q) begin
                state_d = S_CP;
              end else begin
                state_d   = S_IDLE;
                fd_pend_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_CP: begin
          if (bus.in_corr_strobe) begin
            if (cnt_q == CNT_W'(CP_LEN - 1)) begin
              state_d   = S_DATA;
              cnt_d     = '0;
              sym_idx_d = sym_idx_q + SYM_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Gating flags follow the sample they qualify, so they use state_q.
    out_strobe_d       = gate_c && !kill_c;
    sym_start_d        = gate_c && !kill_c && (cnt_q == '0);
    providing_long_d   = (state_q == S_LONG) && !kill_c;
    providing_stream_d = (state_q == S_DATA) && !kill_c;
    corr_en_d          = (state_d == S_CORR);
    phase_calc_en_d    = (state_d == S_CORR) || (state_d == S_WAIT) ||
                         (state_d == S_LONG) || (state_d == S_CP) || (state_d == S_DATA);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!s_RST) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      wait_q             <= '0;
      num_sym_q          <= '0;
      sym_idx_q          <= '0;
      fd_pend_q          <= 1'b0;
      phase_sample_q     <= 1'b0;
      corr_en_q          <= 1'b0;
      phase_calc_en_q    <= 1'b0;
      out_strobe_q       <= 1'b0;
      providing_long_q   <= 1'b0;
      providing_stream_q <= 1'b0;
      sym_start_q        <= 1'b0;
      frame_done_q       <= 1'b0;
      sync_fail_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      wait_q             <= wait_d;
      num_sym_q          <= num_sym_d;
      sym_idx_q          <= sym_idx_d;
      fd_pend_q          <= fd_pend_d;
      phase_sample_q     <= phase_sample_d;
      corr_en_q          <= corr_en_d;
      phase_calc_en_q    <= phase_calc_en_d;
      out_strobe_q       <= out_strobe_d;
      providing_long_q   <= providing_long_d;
      providing_stream_q <= providing_stream_d;
      sym_start_q        <= sym_start_d;
      frame_done_q       <= frame_done_d;
      sync_fail_q        <= sync_fail_d;
    end
  end

  assign bus.phase_sample     = phase_sample_q;
  assign bus.corr_en          = corr_en_q;
  assign bus.phase_calc_en    = phase_calc_en_q;
  assign bus.out_strobe       = out_strobe_q;
  assign bus.providing_long   = providing_long_q;
  assign bus.providing_stream = providing_stream_q;
  assign bus.sym_start        = sym_start_q;
  assign bus.sym_idx          = sym_idx_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.sync_fail        = sync_fail_q;

endmodule
